// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer initiator: one command in, one bus cycle out,
// one response (read data + OK/ERR/TIMEOUT status) back on a valid/ready port.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic        cmd_we,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_status,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_ERR     = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           state_r,      state_s;
    logic [CNT_W-1:0] cnt_r,        cnt_s;
    logic [31:0]      adr_r,        adr_s;
    logic [31:0]      dat_r,        dat_s;
    logic [3:0]       sel_r,        sel_s;
    logic             we_r,         we_s;
    logic             cyc_r,        cyc_s;
    logic             rsp_valid_r,  rsp_valid_s;
    logic [31:0]      rsp_dat_r,    rsp_dat_s;
    logic [1:0]       rsp_status_r, rsp_status_s;

    assign cmd_ready = (state_r == ST_IDLE) && !wb_rst_i;

    // Next-state and next-register values of the transfer sequencer
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        adr_s        = adr_r;
        dat_s        = dat_r;
        sel_s        = sel_r;
        we_s         = we_r;
        cyc_s        = cyc_r;
        rsp_valid_s  = rsp_valid_r;
        rsp_dat_s    = rsp_dat_r;
        rsp_status_s = rsp_status_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_s   = cmd_adr;
                    dat_s   = cmd_dat;
                    sel_s   = cmd_sel;
                    we_s    = cmd_we;
                    cyc_s   = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // err outranks ack, and either outranks the timeout on the same edge
                if (wb_err_i) begin
                    cyc_s        = 1'b0;
                    we_s         = 1'b0;
                    rsp_valid_s  = 1'b1;
                    rsp_status_s = RSP_ERR;
                    rsp_dat_s    = 32'h0000_0000;
                    state_s      = ST_RESP;
                end else if (wb_ack_i) begin
                    cyc_s        = 1'b0;
                    we_s         = 1'b0;
                    rsp_valid_s  = 1'b1;
                    rsp_status_s = RSP_OK;
                    rsp_dat_s    = we_r ? 32'h0000_0000 : wb_dat_i;
                    state_s      = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    cyc_s        = 1'b0;
                    we_s         = 1'b0;
                    rsp_valid_s  = 1'b1;
                    rsp_status_s = RSP_TIMEOUT;
                    rsp_dat_s    = 32'h0000_0000;
                    state_s      = ST_RESP;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cyc_s       = 1'b0;
                we_s        = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            adr_r        <= 32'h0000_0000;
            dat_r        <= 32'h0000_0000;
            sel_r        <= 4'h0;
            we_r         <= 1'b0;
            cyc_r        <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_dat_r    <= 32'h0000_0000;
            rsp_status_r <= 2'b00;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            adr_r        <= adr_s;
            dat_r        <= dat_s;
            sel_r        <= sel_s;
            we_r         <= we_s;
            cyc_r        <= cyc_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_dat_r    <= rsp_dat_s;
            rsp_status_r <= rsp_status_s;
        end
    end

    assign wb_adr_o   = adr_r;
    assign wb_dat_o   = dat_r;
    assign wb_sel_o   = sel_r;
    assign wb_we_o    = we_r;
    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = cyc_r;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_dat    = rsp_dat_r;
    assign rsp_status = rsp_status_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: randomized commands against a scripted
// Wishbone responder, with expected responses derived from the transfer rules.
module tb_wb_cmd_master;
    localparam int T = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic        cmd_we = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;

    wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // responder kinds: 0 never terminates, 1 ack, 2 err, 3 ack+err together
    typedef struct { int kind; int cyc; } plan_t;
    typedef struct { logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic we; int len; } bus_exp_t;
    typedef struct { logic [1:0] st; logic [31:0] dat; int lat; } rsp_exp_t;

    plan_t    plan_q[$];
    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int total = 0;
    int bad = 0;
    int rsp_count = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h4141_4141;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scripted slave: terminates on the planned bus cycle, sprays stray ack/err while idle
    plan_t cur;
    int    r_cnt = 0;
    always begin
        @(negedge wb_clk_i);
        if (wb_cyc_o) begin
            if (r_cnt == 0) begin
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else begin cur.kind = 0; cur.cyc = 0; end
            end
            r_cnt++;
            wb_ack_i = (r_cnt == cur.cyc) && (cur.kind == 1 || cur.kind == 3);
            wb_err_i = (r_cnt == cur.cyc) && (cur.kind >= 2);
            wb_dat_i = (r_cnt == cur.cyc) ? rd_model(wb_adr_o) : $urandom;
        end else begin
            r_cnt = 0;
            wb_ack_i = ($urandom_range(0, 3) == 0);
            wb_err_i = ($urandom_range(0, 3) == 0);
            wb_dat_i = $urandom;
        end
    end

    // consumer: stalls each new response for a chosen number of cycles
    bit seen = 0;
    int stall = 0;
    always begin
        @(negedge wb_clk_i);
        if (rsp_valid) begin
            if (!seen) begin
                seen = 1;
                stall = (rsp_count < 2) ? 0 : (rsp_count == 2) ? 5 : $urandom_range(0, 6);
                rsp_count++;
            end
            if (stall > 0) begin rsp_ready = 1'b0; stall--; end
            else rsp_ready = 1'b1;
        end else begin
            seen = 0;
            rsp_ready = $urandom_range(0, 1);
        end
    end

    // monitor: samples each cycle shortly after the falling edge
    int sidx = 0, acc_idx = 0, cyc_len = 0;
    bit prev_cyc = 0, prev_rv = 0;
    logic [31:0] held_dat;
    logic [1:0]  held_st;
    always begin
        @(negedge wb_clk_i);
        #2;
        sidx++;
        chk("cti", {29'd0, wb_cti_o}, 32'd0);
        chk("bte", {30'd0, wb_bte_o}, 32'd0);
        chk("stb_eq_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !wb_cyc_o && !rsp_valid && !wb_rst_i});
        if (wb_cyc_o && rsp_valid) chk("cyc_with_rsp", 32'd1, 32'd0);
        if (wb_cyc_o) begin
            cyc_len++;
            if (cyc_len == 1) chk("bubble", {31'd0, prev_rv}, 32'd0);
            if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
            else begin
                chk("adr", wb_adr_o, bus_q[0].adr);
                chk("dat_o", wb_dat_o, bus_q[0].dat);
                chk("sel", {28'd0, wb_sel_o}, {28'd0, bus_q[0].sel});
                chk("we", {31'd0, wb_we_o}, {31'd0, bus_q[0].we});
            end
        end else begin
            chk("we_idle", {31'd0, wb_we_o}, 32'd0);
            if (prev_cyc) begin
                if (bus_q.size() > 0) begin
                    chk("cyc_len", cyc_len, bus_q[0].len);
                    void'(bus_q.pop_front());
                end
                cyc_len = 0;
            end
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                if (!prev_rv) begin
                    chk("latency", sidx - acc_idx, rsp_q[0].lat);
                    held_dat = rsp_dat;
                    held_st = rsp_status;
                end else begin
                    chk("rsp_dat_stable", rsp_dat, held_dat);
                    chk("rsp_st_stable", {30'd0, rsp_status}, {30'd0, held_st});
                end
                if (rsp_ready) begin
                    chk("rsp_status", {30'd0, rsp_status}, {30'd0, rsp_q[0].st});
                    chk("rsp_dat", rsp_dat, rsp_q[0].dat);
                    void'(rsp_q.pop_front());
                end
            end
        end
        if (cmd_valid && cmd_ready) acc_idx = sidx;
        prev_cyc = wb_cyc_o;
        prev_rv = rsp_valid;
    end

    // queue expectations, present the command, wait for acceptance; optionally reset mid-transfer
    task automatic send(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input int kind, input int pcyc, input bit abort);
        plan_t    p;
        bus_exp_t b;
        rsp_exp_t r;
        bit       ok;
        bit       term;
        term = (kind != 0) && (pcyc <= T);
        p.kind = kind; p.cyc = pcyc;
        b.adr = adr; b.dat = dat; b.sel = sel; b.we = we;
        b.len = abort ? 3 : (term ? pcyc : T);
        r.st  = !term ? 2'b10 : (kind >= 2) ? 2'b01 : 2'b00;
        r.dat = (term && kind == 1 && !we) ? rd_model(adr) : 32'h0;
        r.lat = b.len + 1;
        plan_q.push_back(p);
        bus_q.push_back(b);
        if (!abort) rsp_q.push_back(r);
        cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_we = we; cmd_valid = 1'b1;
        ok = 0;
        for (int w = 0; w < 300 && !ok; w++) begin
            #1;
            if (cmd_ready) ok = 1;
            else @(negedge wb_clk_i);
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge wb_clk_i);
        if (abort) begin
            cmd_valid = 1'b0;
            @(negedge wb_clk_i);
            @(negedge wb_clk_i);
            wb_rst_i = 1'b1;
            #1 chk("ready_in_rst", {31'd0, cmd_ready}, 32'd0);
            @(negedge wb_clk_i);
            wb_rst_i = 1'b0;
            #3;
            chk("abort_cyc", {31'd0, wb_cyc_o}, 32'd0);
            chk("abort_stb", {31'd0, wb_stb_o}, 32'd0);
            chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 400 && (bus_q.size() + rsp_q.size()) > 0; w++) @(negedge wb_clk_i);
        repeat (3) @(negedge wb_clk_i);
        chk("drain", bus_q.size() + rsp_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk_i);
        #3;
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1 chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        send(32'h0000_0000, 32'h0,         4'hF, 1'b0, 1, 2, 1'b0);
        send(32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 1'b1, 1, 2, 1'b0);
        send(32'h0000_0020, 32'h0,         4'hF, 1'b0, 0, 0, 1'b0);
        send(32'h0000_0030, 32'h0,         4'hF, 1'b0, 3, 1, 1'b0);
        send(32'h0000_0040, 32'h0,         4'hF, 1'b0, 1, T, 1'b0);
        send(32'h0000_0050, 32'h1234_5678, 4'hC, 1'b1, 2, T, 1'b0);
        send(32'h0000_0060, 32'h0,         4'hF, 1'b0, 1, T + 1, 1'b0);
        cmd_valid = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            send($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, T + 2), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge wb_clk_i);
            end
        end
        cmd_valid = 1'b0;
        drain();

        send(32'h0000_0100, 32'h0, 4'hF, 1'b0, 0, 0, 1'b1);
        repeat (4) @(negedge wb_clk_i);
        send(32'h0000_0104, 32'h0, 4'hF, 1'b0, 1, 2, 1'b0);
        cmd_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck expected finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
